// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: execute redirect, instruction-memory request/response
// channel and the instruction hand-off to decode.
interface ifetch_if;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   modport master (
      input  redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, inst_ready,
      output imem_req, imem_addr, inst_valid, inst, inst_pc
   );

   modport slave (
      output redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, inst_ready,
      input  imem_req, imem_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the fetch PC, keeps at most one imem read in flight and
// buffers returned words in a 2-entry FIFO for decode; redirects flush everything.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic     clk,
   input  logic     reset,
   ifetch_if.master bus
);
   logic [31:0] fetch_pc;
   logic [31:0] tag_pc;
   logic        outstanding;
   logic        drop;
   logic [1:0]  count;
   logic [31:0] pc0, pc1, word0, word1;

   logic        inst_vld;
   logic        pop;
   logic        req;
   logic        accept;
   logic        resp;
   logic        push;
   logic        wr_slot;
   logic [2:0]  occ;

   always_comb begin
      inst_vld = !reset && (count != 2'd0);
      pop      = inst_vld && bus.inst_ready;
      occ      = 3'(count) + 3'(outstanding) - 3'(pop);
      // A returning response frees the request slot in the same cycle.
      req      = !reset && !bus.redirect && (!outstanding || bus.imem_rvalid) && (occ < 3'd2);
      accept   = req && bus.imem_ready;
      resp     = outstanding && bus.imem_rvalid;
      push     = resp && !drop && !bus.redirect;
      wr_slot  = (count == 2'd2) || ((count == 2'd1) && !pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         count       <= 2'd0;
         outstanding <= 1'b0;
         drop        <= 1'b0;
      end else if (bus.redirect) begin
         fetch_pc    <= bus.redirect_pc & ~32'd3;
         count       <= 2'd0;
         // An in-flight read that has not returned yet must be thrown away later.
         outstanding <= outstanding && !bus.imem_rvalid;
         drop        <= outstanding && !bus.imem_rvalid;
      end else begin
         if (accept)
            fetch_pc <= fetch_pc + 32'd4;
         outstanding <= accept || (outstanding && !bus.imem_rvalid);
         if (resp)
            drop <= 1'b0;
         count <= count + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         tag_pc <= fetch_pc;
      if (pop) begin
         pc0   <= pc1;
         word0 <= word1;
      end
      if (push) begin
         if (wr_slot) begin
            pc1   <= tag_pc;
            word1 <= bus.imem_rdata;
         end else begin
            pc0   <= tag_pc;
            word0 <= bus.imem_rdata;
         end
      end
   end

   assign bus.imem_req   = req;
   assign bus.imem_addr  = fetch_pc;
   assign bus.inst_valid = inst_vld;
   assign bus.inst       = inst_vld ? word0 : 32'd0;
   assign bus.inst_pc    = inst_vld ? pc0 : 32'd0;
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit: an in-order memory model and a
// sequential-PC reference stream that restarts on reset and redirect.
module tb_ifetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ifetch_if bus ();

   ifetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   int          n_vec = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          n_pop = 0;
   pend_t       pend[$];
   logic [31:0] exp_q[$];
   logic [31:0] req_pc;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hA5A5_A5A5;
   endfunction

   function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Expected decode stream: consecutive words starting at the restart address.
   function void reseed(input logic [31:0] t);
      exp_q.delete();
      for (int i = 0; i < 4; i++)
         exp_q.push_back(t + 32'(4 * i));
      req_pc = t;
   endfunction

   // Memory: in-order responses, latency lat_min..lat_max cycles after acceptance.
   initial begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = word_of(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
         end
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_req", 32'(bus.imem_req), 32'd0);
         chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
         pend.delete();
         reseed(RST_PC);
         prev_stall = 1'b0;
      end else begin
         if (!bus.inst_valid) begin
            chk("empty_inst", bus.inst, 32'd0);
            chk("empty_inst_pc", bus.inst_pc, 32'd0);
         end
         if (prev_stall && !bus.redirect) begin
            chk("hold_req", 32'(bus.imem_req), 32'd1);
            chk("hold_addr", bus.imem_addr, prev_addr);
         end
         if (bus.inst_valid && bus.inst_ready) begin
            chk("inst_pc", bus.inst_pc, exp_q[0]);
            chk("inst", bus.inst, word_of(exp_q[0]));
            void'(exp_q.pop_front());
            exp_q.push_back(exp_q[exp_q.size() - 1] + 32'd4);
            n_pop++;
         end
         if (bus.redirect)
            chk("redirect_req", 32'(bus.imem_req), 32'd0);
         if (bus.imem_req && bus.imem_ready) begin
            chk("req_addr", bus.imem_addr, req_pc);
            req_pc = req_pc + 32'd4;
            pend.push_back('{bus.imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
         end
         prev_stall = bus.imem_req && !bus.imem_ready;
         prev_addr  = bus.imem_addr;
         if (bus.redirect)
            reseed(bus.redirect_pc & ~32'd3);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      bus.redirect = 1'b0;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   function automatic bit cond(input int k);
      case (k)
         0:       return bus.imem_req && bus.imem_ready && (bus.imem_addr == 32'h8);
         1:       return bus.imem_req;
         2:       return bus.inst_valid;
         default: return bus.imem_req && bus.imem_ready && (bus.imem_addr == 32'h0);
      endcase
   endfunction

   // Leaves time at posedge+1 of the cycle after the event (or after budget).
   task automatic wait_for(input int k, input int budget, output bit found, output logic [31:0] addr);
      found = 1'b0;
      addr  = 32'd0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (cond(k)) begin
            found = 1'b1;
            addr  = (k == 2) ? bus.inst_pc : bus.imem_addr;
         end
         tick();
      end
   endtask

   initial begin
      bit          found;
      logic [31:0] a;
      int          acc;

      reset           = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.imem_ready  = 1'b1;
      bus.inst_ready  = 1'b1;
      tick();

      // Free run, 1-cycle memory, decode always ready
      do_reset(3);
      @(negedge clk);
      chk("first_req", 32'(bus.imem_req), 32'd1);
      chk("first_addr", bus.imem_addr, RST_PC);
      wait_for(2, 10, found, a);
      chk("first_inst_seen", 32'(found), 32'd1);
      repeat (15) begin
         @(negedge clk);
         chk("throughput_valid", 32'(bus.inst_valid), 32'd1);
         tick();
      end

      // Decode stalled: FIFO fills to two, then fetch resumes on the first pop
      bus.inst_ready = 1'b0;
      do_reset(2);
      acc = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.imem_req && bus.imem_ready) acc++;
         tick();
      end
      chk("stall_accepts", 32'(acc), 32'd2);
      @(negedge clk);
      chk("stall_req_low", 32'(bus.imem_req), 32'd0);
      tick();
      bus.inst_ready = 1'b1;
      @(negedge clk);
      chk("resume_req", 32'(bus.imem_req), 32'd1);
      chk("resume_addr", bus.imem_addr, 32'h8);
      chk("resume_pop", 32'(bus.inst_valid), 32'd1);
      tick();

      // imem_ready low for three cycles on the request to 0x4
      do_reset(2);
      tick();
      bus.imem_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("ready_low_req", 32'(bus.imem_req), 32'd1);
         chk("ready_low_addr", bus.imem_addr, 32'h4);
         tick();
      end
      bus.imem_ready = 1'b1;
      @(negedge clk);
      chk("ready_high_addr", bus.imem_addr, 32'h4);
      tick();
      repeat (5) tick();

      // Redirect while the read of 0x8 is still in flight
      lat_min = 3;
      lat_max = 3;
      do_reset(2);
      wait_for(0, 30, found, a);
      chk("saw_accept_0x8", 32'(found), 32'd1);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0103;
      tick();
      bus.redirect = 1'b0;
      @(negedge clk);
      chk("redir_inst_valid_low", 32'(bus.inst_valid), 32'd0);
      wait_for(1, 10, found, a);
      chk("redir_req_seen", 32'(found), 32'd1);
      chk("redir_first_addr", a, 32'h100);
      wait_for(2, 20, found, a);
      chk("redir_first_inst_pc", a, 32'h100);

      // Redirect coinciding with a response and a pop
      lat_min = 1;
      lat_max = 1;
      do_reset(2);
      repeat (6) tick();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0200;
      @(negedge clk);
      chk("redir_rvalid", 32'(bus.imem_rvalid), 32'd1);
      chk("redir_pop", 32'(bus.inst_valid && bus.inst_ready), 32'd1);
      tick();
      bus.redirect = 1'b0;
      @(negedge clk);
      chk("redir2_empty", 32'(bus.inst_valid), 32'd0);
      chk("redir2_req", 32'(bus.imem_req), 32'd1);
      chk("redir2_addr", bus.imem_addr, 32'h200);
      tick();

      // Address wrap at the top of memory
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFF8;
      tick();
      bus.redirect = 1'b0;
      wait_for(3, 10, found, a);
      chk("wrap_to_zero", 32'(found), 32'd1);
      repeat (4) tick();

      // Reset in the middle of a stream
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_req", 32'(bus.imem_req), 32'd1);
      chk("midrst_addr", bus.imem_addr, RST_PC);
      chk("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
      tick();

      // Randomized traffic
      lat_min = 1;
      lat_max = 3;
      n_pop   = 0;
      repeat (3000) begin
         bus.imem_ready  = ($urandom_range(99, 0) < 75);
         bus.inst_ready  = ($urandom_range(99, 0) < 70);
         bus.redirect    = ($urandom_range(99, 0) < 3);
         bus.redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0)) : $urandom;
         reset           = ($urandom_range(199, 0) == 0);
         tick();
      end
      reset        = 1'b0;
      bus.redirect = 1'b0;
      repeat (5) tick();
      chk("random_progress", 32'(n_pop > 300), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit for the RISC-V core. It owns the architectural fetch PC and issues word reads to instruction memory over a valid/ready request channel. Returned instruction words go into a 2-entry buffer and are handed to decode with a valid/ready handshake. It also handles control-flow redirects from execute by flushing the buffer and discarding any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset; must be 4-byte aligned.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- redirect  in  1  execute requests a fetch restart (taken branch or jump).
- redirect_pc  in  32  restart target; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  request valid.
- imem_addr  out  32  word address of the request; always 4-byte aligned.
- imem_ready  in  1  memory accepts the request when imem_req && imem_ready.
- imem_rvalid  in  1  response valid, one cycle wide, in request order.
- imem_rdata  in  32  instruction word, qualified by imem_rvalid.
- inst_valid  out  1  buffer head holds a valid instruction.
- inst  out  32  instruction word at buffer head.
- inst_pc  out  32  address the head instruction was fetched from.
- inst_ready  in  1  decode consumes the head when inst_valid && inst_ready.

## Operation
- State:
  - fetch_pc (32 b): address of the next request.
  - outstanding (1 b): a request was accepted and its response has not returned.
  - drop (1 b): the outstanding response must be discarded.
  - 2-entry FIFO of {pc, word} with a count of 0..2.
- Occupancy is count + outstanding and never exceeds 2.
- imem_req = !reset && !redirect && (!outstanding || imem_rvalid) && (count + outstanding − pop < 2).
  - pop = inst_valid && inst_ready.
  - imem_addr = fetch_pc.
- Accept (imem_req && imem_ready): fetch_pc ← fetch_pc + 4, with 32-bit wrap (32'hFFFF_FFFC → 0). Outstanding is set and carries the address for tagging.
- Response (imem_rvalid while outstanding):
  - If drop = 0, push {tag pc, imem_rdata}.
  - If drop = 1, discard the word and clear drop.
  - In both cases outstanding clears unless a new request is accepted in the same cycle.
  - imem_rvalid while !outstanding is a protocol error; ignore it.
- Push and pop in the same cycle are legal; count is unchanged.
- Redirect (priority over everything except reset):
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - FIFO count ← 0.
  - If outstanding and no imem_rvalid this cycle, drop ← 1.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle still completes as a handshake; decode owns the kill.
- Back-to-back redirects: each one overwrites fetch_pc; drop stays set if it is already pending.
- Once asserted, imem_req may drop only on redirect or reset. Otherwise it holds with a stable imem_addr until accepted.

## Timing
- Reset values: fetch_pc = RESET_PC, count = 0, outstanding = 0, drop = 0.
  - imem_req = 0 and inst_valid = 0 during any cycle with reset high.
  - inst and inst_pc are 0 when empty.
- First request: the cycle after reset deasserts, with imem_addr = RESET_PC.
- Reset mid-operation: the next edge restores all reset values. An in-flight response arriving after reset is ignored because outstanding = 0.
- Memory response latency is ≥1 cycle after acceptance.
- Latency: rvalid at edge N makes the instruction visible on inst/inst_valid after edge N.
- Throughput:
  - With 1-cycle memory and decode always ready: one instruction per cycle.
  - Next request overlaps with the cycle the previous response returns.
- Stall: with decode stalled, the FIFO fills to 2 and imem_req stays low. Fetch resumes in the same cycle decode pops.
- Redirect at edge N: first request to the new target is in cycle N+1; inst_valid is low in cycle N+1.

## Test plan
- Reset then free-run, 1-cycle memory returning addr^32'hA5A5_A5A5, inst_ready = 1 → requests 0x0, 0x4, 0x8… one per cycle; inst_pc/inst match in order, with no gaps after the first.
- Decode held off 10 cycles → exactly 2 accepted requests (0x0, 0x4); imem_req low afterwards. On release, 0x8 is requested in the same cycle as the first pop.
- imem_ready low for 3 cycles on the request to 0x4 → imem_addr is stable at 0x4 throughout; no duplicate or skipped address.
- Redirect to 0x0000_0103 while the request to 0x8 is outstanding → its response is dropped; next request is 0x100; next inst_pc is 0x100.
- Redirect in the same cycle as imem_rvalid and a pop → popped instruction transfers; arriving word discarded; FIFO empty; next request is the target.
- RESET_PC = 32'hFFFF_FFF8 → fetch order FFFF_FFF8, FFFF_FFFC, 0000_0000. Asserting reset mid-stream returns to FFFF_FFF8 with inst_valid low.
